// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO pointer/flag controller family.
// Combinational content only; no clocked state in this file.
package fifo_ctrl_pkg;

  function automatic int f_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: advances one cycle after i_inc, wraps DEPTH-1 -> 0.
// Synchronous active-low reset and soft clear both return it to 0; no backpressure.
module fifo_wrap_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = f_aw(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);

  localparam logic [AW-1:0] P_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] P_ONE  = AW'(1);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == P_LAST) ? '0 : r_ptr + P_ONE;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_gen2.sv
// FIFO pointer/flag controller for an external dual-port RAM of any DEPTH >= 2.
// Enables are combinational from registered flags; pointers/count/flags update one cycle later.
module fifo_ctrl_gen2
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1,
  localparam int AW = f_aw(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic          i_rd,
  output logic          o_wen,
  output logic          o_ren,
  output logic [AW-1:0] o_waddr,
  output logic [AW-1:0] o_raddr,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_afull,
  output logic          o_aempty,
  output logic          o_overflow,
  output logic          o_underflow
);

  localparam logic [AW:0] C_DEPTH  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] C_AFULL  = (AW + 1)'(AFULL_TH);
  localparam logic [AW:0] C_AEMPTY = (AW + 1)'(AEMPTY_TH);
  localparam logic [AW:0] C_ONE    = (AW + 1)'(1);

  fifo_flags_t r_flags;
  logic [AW:0] r_count;
  logic [AW:0] w_count_nxt;
  logic        w_go;
  logic        w_wen;
  logic        w_ren;

  // A cycle that resets or clears accepts nothing, so the RAM is never written during it.
  assign w_go  = i_rstn & ~i_clr;
  assign w_ren = w_go & i_rd & ~r_flags.empty;
  assign w_wen = w_go & i_wr & (~r_flags.full | w_ren);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wen && !w_ren) begin
      w_count_nxt = r_count + C_ONE;
    end else if (w_ren && !w_wen) begin
      w_count_nxt = r_count - C_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr) begin
      r_count           <= '0;
      r_flags.full      <= 1'b0;
      r_flags.empty     <= 1'b1;
      r_flags.afull     <= 1'b0;
      r_flags.aempty    <= 1'b1;
      r_flags.overflow  <= 1'b0;
      r_flags.underflow <= 1'b0;
    end else begin
      r_count           <= w_count_nxt;
      r_flags.full      <= (w_count_nxt == C_DEPTH);
      r_flags.empty     <= (w_count_nxt == '0);
      r_flags.afull     <= (w_count_nxt >= C_AFULL);
      r_flags.aempty    <= (w_count_nxt <= C_AEMPTY);
      r_flags.overflow  <= r_flags.overflow  | (i_wr & ~w_wen);
      r_flags.underflow <= r_flags.underflow | (i_rd & ~w_ren);
    end
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (i_clr),
    .i_inc  (w_wen),
    .o_ptr  (o_waddr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (i_clr),
    .i_inc  (w_ren),
    .o_ptr  (o_raddr)
  );

  assign o_wen       = w_wen;
  assign o_ren       = w_ren;
  assign o_count     = r_count;
  assign o_full      = r_flags.full;
  assign o_empty     = r_flags.empty;
  assign o_afull     = r_flags.afull;
  assign o_aempty    = r_flags.aempty;
  assign o_overflow  = r_flags.overflow;
  assign o_underflow = r_flags.underflow;

endmodule

// File: tb/tb_fifo_ctrl_gen2.sv
// Bench for fifo_ctrl_gen2: directed vector table at DEPTH=6, wrap sequence,
// and a randomized run at DEPTH=16 against a queue-occupancy reference model.
module tb_fifo_ctrl_gen2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=6 instance
  logic       a_rstn = 1'b0, a_clr = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
  logic       a_wen, a_ren, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [2:0] a_waddr, a_raddr;
  logic [3:0] a_count;

  // DEPTH=16 instance
  logic       b_rstn = 1'b0, b_clr = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
  logic       b_wen, b_ren, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [3:0] b_waddr, b_raddr;
  logic [4:0] b_count;

  fifo_ctrl_gen2 #(.DEPTH(6)) u_dut6 (
    .i_clk(clk), .i_rstn(a_rstn), .i_clr(a_clr), .i_wr(a_wr), .i_rd(a_rd),
    .o_wen(a_wen), .o_ren(a_ren), .o_waddr(a_waddr), .o_raddr(a_raddr),
    .o_count(a_count), .o_full(a_full), .o_empty(a_empty), .o_afull(a_afull),
    .o_aempty(a_aempty), .o_overflow(a_ovf), .o_underflow(a_unf)
  );

  fifo_ctrl_gen2 #(.DEPTH(16)) u_dut16 (
    .i_clk(clk), .i_rstn(b_rstn), .i_clr(b_clr), .i_wr(b_wr), .i_rd(b_rd),
    .o_wen(b_wen), .o_ren(b_ren), .o_waddr(b_waddr), .o_raddr(b_raddr),
    .o_count(b_count), .o_full(b_full), .o_empty(b_empty), .o_afull(b_afull),
    .o_aempty(b_aempty), .o_overflow(b_ovf), .o_underflow(b_unf)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // flags packed as {full, empty, afull, aempty, overflow, underflow}
  typedef struct {
    logic       rstn, clr, wr, rd;
    logic       wen, ren;
    int         waddr, raddr, count;
    logic [5:0] flags;
  } vec_t;

  localparam int NV = 24;
  vec_t tv [NV];

  function automatic vec_t mk(input logic rstn, clr, wr, rd, wen, ren,
                              input int wa, ra, cnt, input logic [5:0] fl);
    vec_t v;
    v.rstn = rstn; v.clr = clr; v.wr = wr; v.rd = rd;
    v.wen = wen; v.ren = ren; v.waddr = wa; v.raddr = ra; v.count = cnt; v.flags = fl;
    return v;
  endfunction

  int         wraps;
  int         n_wr, n_rd, m_cnt, wp;
  logic       m_ovf, m_unf, e_wen, e_ren, inv_ok;
  logic [5:0] e_flags;
  int         diff;

  initial begin
    //          rstn clr wr rd | wen ren | wa ra cnt | flags
    tv[0]  = mk(0, 0, 1, 0,  0, 0,  0, 0, 0, 6'b010100); // reset with wr pending
    tv[1]  = mk(1, 0, 1, 0,  1, 0,  1, 0, 1, 6'b000100);
    tv[2]  = mk(1, 0, 1, 0,  1, 0,  2, 0, 2, 6'b000000);
    tv[3]  = mk(1, 0, 1, 0,  1, 0,  3, 0, 3, 6'b000000);
    tv[4]  = mk(1, 0, 1, 0,  1, 0,  4, 0, 4, 6'b001000); // afull at 4
    tv[5]  = mk(1, 0, 1, 0,  1, 0,  5, 0, 5, 6'b001000);
    tv[6]  = mk(1, 0, 1, 0,  1, 0,  0, 0, 6, 6'b101000); // full, waddr wrapped
    tv[7]  = mk(1, 0, 1, 0,  0, 0,  0, 0, 6, 6'b101010); // 7th write rejected
    tv[8]  = mk(1, 0, 0, 1,  0, 1,  0, 1, 5, 6'b001010);
    tv[9]  = mk(1, 0, 0, 1,  0, 1,  0, 2, 4, 6'b001010);
    tv[10] = mk(1, 0, 0, 1,  0, 1,  0, 3, 3, 6'b000010); // count 3, overflow set
    tv[11] = mk(0, 0, 1, 0,  0, 0,  0, 0, 0, 6'b010100); // mid-stream reset
    tv[12] = mk(1, 0, 1, 0,  1, 0,  1, 0, 1, 6'b000100);
    tv[13] = mk(1, 0, 1, 0,  1, 0,  2, 0, 2, 6'b000000);
    tv[14] = mk(1, 0, 1, 0,  1, 0,  3, 0, 3, 6'b000000);
    tv[15] = mk(1, 0, 1, 0,  1, 0,  4, 0, 4, 6'b001000);
    tv[16] = mk(1, 0, 1, 0,  1, 0,  5, 0, 5, 6'b001000);
    tv[17] = mk(1, 0, 1, 0,  1, 0,  0, 0, 6, 6'b101000);
    tv[18] = mk(1, 0, 1, 1,  1, 1,  1, 1, 6, 6'b101000); // full, wr&rd both accepted
    tv[19] = mk(1, 0, 0, 1,  0, 1,  1, 2, 5, 6'b001000);
    tv[20] = mk(1, 1, 1, 1,  0, 0,  0, 0, 0, 6'b010100); // soft clear blocks both
    tv[21] = mk(1, 0, 0, 1,  0, 0,  0, 0, 0, 6'b010101); // underflow
    tv[22] = mk(1, 0, 1, 1,  1, 0,  1, 0, 1, 6'b000101); // no read bypass when empty
    tv[23] = mk(1, 0, 0, 1,  0, 1,  1, 1, 0, 6'b010101);

    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      a_rstn = tv[i].rstn; a_clr = tv[i].clr; a_wr = tv[i].wr; a_rd = tv[i].rd;
      #2;
      chk($sformatf("v%0d.wen", i), 32'(a_wen), 32'(tv[i].wen));
      chk($sformatf("v%0d.ren", i), 32'(a_ren), 32'(tv[i].ren));
      @(posedge clk); #1;
      chk($sformatf("v%0d.waddr", i), 32'(a_waddr), tv[i].waddr);
      chk($sformatf("v%0d.raddr", i), 32'(a_raddr), tv[i].raddr);
      chk($sformatf("v%0d.count", i), 32'(a_count), tv[i].count);
      chk($sformatf("v%0d.flags", i),
          32'({a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf}), 32'(tv[i].flags));
    end

    // Wrap: 20 write-then-read pairs, pointers must follow (k mod 6)
    a_rstn = 1'b1; a_clr = 1'b1; a_wr = 1'b0; a_rd = 1'b0;
    @(posedge clk); #1;
    a_clr = 1'b0;
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      a_wr = 1'b1; a_rd = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("wrap%0d.waddr", i), 32'(a_waddr), (i + 1) % 6);
      chk($sformatf("wrap%0d.cnt1", i), 32'(a_count), 1);
      if (a_waddr == 3'd0) wraps++;
      a_wr = 1'b0; a_rd = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("wrap%0d.raddr", i), 32'(a_raddr), (i + 1) % 6);
      chk($sformatf("wrap%0d.cnt0", i), 32'(a_count), 0);
    end
    a_rd = 1'b0;
    chk("wrap.count_of_wraps", 32'(wraps), 3);

    // Randomized run at DEPTH=16; model tracks totals written/read
    b_rstn = 1'b0;
    @(posedge clk); #1;
    b_rstn = 1'b1;
    n_wr = 0; n_rd = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      wp    = ((cyc / 400) % 2 == 1) ? 75 : 25;
      b_wr  = ($urandom_range(99) < wp);
      b_rd  = ($urandom_range(99) < (100 - wp));
      b_clr = ($urandom_range(999) == 0);
      #2;
      m_cnt = n_wr - n_rd;
      e_ren = !b_clr && b_rd && (m_cnt > 0);
      e_wen = !b_clr && b_wr && ((m_cnt < 16) || e_ren);
      chk($sformatf("rnd%0d.accept", cyc), 32'({b_wen, b_ren}), 32'({e_wen, e_ren}));
      @(posedge clk); #1;
      if (b_clr) begin
        n_wr = 0; n_rd = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        if (e_wen) n_wr++;
        if (e_ren) n_rd++;
        m_ovf = m_ovf | (b_wr & !e_wen);
        m_unf = m_unf | (b_rd & !e_ren);
      end
      m_cnt   = n_wr - n_rd;
      e_flags = {m_cnt == 16, m_cnt == 0, m_cnt >= 14, m_cnt <= 1, m_ovf, m_unf};
      chk($sformatf("rnd%0d.state", cyc),
          32'({b_waddr, b_raddr, b_count, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf}),
          32'({4'(n_wr % 16), 4'(n_rd % 16), 5'(m_cnt), e_flags}));
      diff   = (int'(b_waddr) - int'(b_raddr) + 16) % 16;
      inv_ok = ((b_waddr != b_raddr) || b_empty || b_full) && !(b_full && b_empty) &&
               (b_full || (int'(b_count) == diff));
      chk($sformatf("rnd%0d.invariants", cyc), 32'(inv_ok), 32'd1);
    end
    b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
